// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register sequencer: opcodes, FSM states,
// instruction field positions and the opcode legality check.
package reg_seq_pkg;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  // The ALU select is the low three opcode bits of a legal opcode.
  localparam logic [2:0] ALU_LOADI = 3'd0;
  localparam logic [2:0] ALU_MOV   = 3'd1;
  localparam logic [2:0] ALU_ADD   = 3'd2;
  localparam logic [2:0] ALU_SUB   = 3'd3;
  localparam logic [2:0] ALU_AND   = 3'd4;
  localparam logic [2:0] ALU_OR    = 3'd5;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 24;
  localparam int DST_MSB  = 18;
  localparam int DST_LSB  = 16;
  localparam int SRC1_MSB = 10;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_MSB = 7;
  localparam int SRC2_LSB = 0;

  function automatic logic op_legal(input logic [7:0] op);
    return (op <= OP_OR);
  endfunction

endpackage

// File: rtl/reg_sequencer_alu.sv
// Combinational 8-bit ALU; loadi and mov both pass operand b through,
// the caller places the immediate on b for loadi.
module alu
  import reg_seq_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [2:0] sel_i,
  output logic [7:0] y_o
);

  always_comb begin
    y_o = '0;
    case (sel_i)
      ALU_LOADI: y_o = b_i;
      ALU_MOV:   y_o = b_i;
      ALU_ADD:   y_o = a_i + b_i;
      ALU_SUB:   y_o = a_i - b_i;
      ALU_AND:   y_o = a_i & b_i;
      ALU_OR:    y_o = a_i | b_i;
      default:   y_o = '0;
    endcase
  end

endmodule

// File: rtl/reg_sequencer.sv
// Four-state instruction sequencer driving an external 8x8 register file:
// accept, read operands, execute, write back.
module reg_sequencer
  import reg_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  input  logic [7:0]  REGOUT1,
  input  logic [7:0]  REGOUT2,
  output logic [2:0]  OUT1ADDRESS,
  output logic [2:0]  OUT2ADDRESS,
  output logic [2:0]  INADDRESS,
  output logic [7:0]  REGIN,
  output logic        WRITE,
  output logic        DONE,
  output logic        ERR
);

  state_e      state_q, state_d;
  logic [7:0]  opc_q;
  logic [2:0]  dst_q;
  logic [2:0]  src1_q;
  logic [7:0]  src2_q;
  logic [7:0]  regin_q;
  logic [2:0]  inaddr_q;
  logic        illegal_q;
  logic        accept;
  logic [7:0]  alu_b;
  logic [7:0]  alu_y;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^{INSTR[23:19], INSTR[15:11]};
  assign accept = INSTR_VALID && (state_q == IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (INSTR_VALID) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    INSTR_READY = (state_q == IDLE);
    DONE        = (state_q == WB);
    WRITE       = (state_q == WB) && !illegal_q;
    ERR         = (state_q == WB) && illegal_q;
  end

  // Operands are registered in EXEC, so a dest that aliases a source still
  // sees the pre-write value.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      opc_q     <= '0;
      dst_q     <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      regin_q   <= '0;
      inaddr_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        opc_q  <= INSTR[OPC_MSB:OPC_LSB];
        dst_q  <= INSTR[DST_MSB:DST_LSB];
        src1_q <= INSTR[SRC1_MSB:SRC1_LSB];
        src2_q <= INSTR[SRC2_MSB:SRC2_LSB];
      end
      if (state_q == EXEC) begin
        illegal_q <= !op_legal(opc_q);
        if (op_legal(opc_q)) begin
          regin_q  <= alu_y;
          inaddr_q <= dst_q;
        end
      end
    end
  end

  assign alu_b = (opc_q == OP_LOADI) ? src2_q : REGOUT2;

  alu u_alu (
    .a_i   (REGOUT1),
    .b_i   (alu_b),
    .sel_i (opc_q[2:0]),
    .y_o   (alu_y)
  );

  assign OUT1ADDRESS = src1_q;
  assign OUT2ADDRESS = src2_q[2:0];
  assign INADDRESS   = inaddr_q;
  assign REGIN       = regin_q;

endmodule

// File: tb/tb_reg_sequencer.sv
// Scoreboard bench for reg_sequencer with a behavioural register file.
module tb_reg_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [7:0]  REGOUT1, REGOUT2;
  logic [2:0]  OUT1ADDRESS, OUT2ADDRESS, INADDRESS;
  logic [7:0]  REGIN;
  logic        WRITE, DONE, ERR;

  reg_sequencer dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .REGOUT1(REGOUT1), .REGOUT2(REGOUT2),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .INADDRESS(INADDRESS), .REGIN(REGIN), .WRITE(WRITE), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  logic [7:0] rf [8];
  assign REGOUT1 = rf[OUT1ADDRESS];
  assign REGOUT2 = rf[OUT2ADDRESS];
  always @(posedge CLK) if (WRITE) rf[INADDRESS] <= REGIN;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic       w;
    logic [2:0] a;
    logic [7:0] d;
    logic       e;
    int         acc;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;
  int last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [2:0] d,
                                     input logic [2:0] s1, input logic [7:0] s2);
    return {op, 5'b0, d, 5'b0, s1, s2};
  endfunction

  // Monitor: retire pops the scoreboard; READY must be back the cycle after.
  logic ready_pending = 1'b0;
  always @(negedge CLK) begin
    if (!RESET) begin
      if (ready_pending) chk("ready_after_done", INSTR_READY, 1'b1);
      ready_pending = 1'b0;
      if (DONE) begin
        ready_pending = 1'b1;
        if (q.size() == 0) begin
          chk("unexpected_done", DONE, 1'b0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("write", WRITE, e.w);
          chk("err", ERR, e.e);
          chk("wb_latency", cyc - e.acc, 2);
          if (e.w) begin
            chk("inaddress", INADDRESS, e.a);
            chk("regin", REGIN, e.d);
          end
        end
      end else if (WRITE || ERR) begin
        chk("stray_pulse", {WRITE, ERR}, 2'b00);
      end
    end else begin
      ready_pending = 1'b0;
    end
  end

  task automatic send(input logic [31:0] ins, input logic push, input logic hold,
                      input logic w, input logic [2:0] a, input logic [7:0] d, input logic e);
    int n = 0;
    exp_t x;
    INSTR = ins;
    INSTR_VALID = 1'b1;
    while (!INSTR_READY && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    if (!INSTR_READY) chk("accept_timeout", INSTR_READY, 1'b1);
    @(posedge CLK); #1;
    last_acc = cyc;
    x.w = w; x.a = a; x.d = d; x.e = e; x.acc = cyc;
    if (push) q.push_back(x);
    if (!hold) INSTR_VALID = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge CLK); #1; n++;
    end
    chk("drain", q.size(), 0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  int acc_t [3];

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    RESET = 1'b1;
    INSTR_VALID = 1'b1;
    INSTR = mk(8'h00, 3'd3, 3'd0, 8'h55);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    INSTR_VALID = 1'b0;
    chk("rst_ready", INSTR_READY, 1'b1);
    chk("rst_write", WRITE, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_addr", {OUT1ADDRESS, OUT2ADDRESS, INADDRESS}, 9'd0);
    chk("rst_regin", REGIN, 8'h00);
    @(posedge CLK); #1;
    chk("rst_valid_not_taken", INSTR_READY, 1'b1);

    send(mk(8'h00, 3'd3, 3'd0, 8'h2A), 1, 0, 1, 3'd3, 8'h2A, 0);
    send(mk(8'h00, 3'd1, 3'd0, 8'hF0), 1, 0, 1, 3'd1, 8'hF0, 0);
    send(mk(8'h00, 3'd2, 3'd0, 8'h20), 1, 0, 1, 3'd2, 8'h20, 0);
    send(mk(8'h02, 3'd4, 3'd1, 8'h02), 1, 0, 1, 3'd4, 8'h10, 0);
    send(mk(8'h03, 3'd5, 3'd2, 8'h01), 1, 0, 1, 3'd5, 8'h30, 0);
    send(mk(8'h01, 3'd6, 3'd0, 8'h03), 1, 0, 1, 3'd6, 8'h2A, 0);
    send(mk(8'h05, 3'd0, 3'd1, 8'h05), 1, 0, 1, 3'd0, 8'hF0, 0);
    send(mk(8'h07, 3'd1, 3'd1, 8'h01), 1, 0, 0, 3'd0, 8'h00, 1);
    drain();
    chk("rf1_kept_after_illegal", rf[1], 8'hF0);

    send(mk(8'h00, 3'd2, 3'd0, 8'hCC), 1, 0, 1, 3'd2, 8'hCC, 0);
    send(mk(8'h00, 3'd7, 3'd0, 8'h0F), 1, 0, 1, 3'd7, 8'h0F, 0);
    send(mk(8'h04, 3'd2, 3'd2, 8'h07), 1, 0, 1, 3'd2, 8'h0C, 0);
    drain();
    chk("rf2_and_result", rf[2], 8'h0C);

    // Valid held high across three queued instructions.
    send(mk(8'h00, 3'd4, 3'd0, 8'h11), 1, 1, 1, 3'd4, 8'h11, 0); acc_t[0] = last_acc;
    send(mk(8'h02, 3'd5, 3'd4, 8'h04), 1, 1, 1, 3'd5, 8'h22, 0); acc_t[1] = last_acc;
    send(mk(8'h03, 3'd6, 3'd5, 8'h07), 1, 0, 1, 3'd6, 8'h13, 0); acc_t[2] = last_acc;
    chk("b2b_gap0", acc_t[1] - acc_t[0], 4);
    chk("b2b_gap1", acc_t[2] - acc_t[1], 4);
    drain();

    // Abort an add in EXEC; rf[3] must keep 0x2A.
    send(mk(8'h02, 3'd3, 3'd1, 8'h02), 0, 0, 0, 3'd0, 8'h00, 0);
    @(posedge CLK); #1;
    chk("exec_not_ready", INSTR_READY, 1'b0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("abort_ready", INSTR_READY, 1'b1);
    chk("abort_write", WRITE, 1'b0);
    repeat (6) @(posedge CLK);
    #1;
    chk("abort_rf3", rf[3], 8'h2A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
